// File: rtl/npu_seq_pkg.sv
// npu_seq_pkg: shared FSM states and result-entry layout for npu_job_sequencer.
// Build option NPU_SEQ_CYCLE_COUNT_EN adds a latency field to every result entry.
package npu_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_NRST,
        S_GAP,
        S_START,
        S_RUN,
        S_PUSH
    } state_t;

`ifdef NPU_SEQ_CYCLE_COUNT_EN
    localparam bit CYC_EN = 1'b1;
`else
    localparam bit CYC_EN = 1'b0;
`endif

    // Entry layout, LSB first: class, timeout flag, optional cycle count.
    function automatic int entry_w(input int class_w, input int tmo_w);
        return class_w + 1 + (CYC_EN ? tmo_w : 0);
    endfunction

    function automatic int to_bit(input int class_w);
        return class_w;
    endfunction

    function automatic int cyc_lsb(input int class_w);
        return class_w + 1;
    endfunction

endpackage

// File: rtl/npu_result_fifo.sv
// npu_result_fifo: synchronous first-word-fall-through FIFO with full/empty/count.
module npu_result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = count == '0;
    assign full    = count == (AW+1)'(DEPTH);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp];

    // Storage carries no reset; only entries behind the count are ever presented.
    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= wp + AW'(do_push);
            rp    <= rp + AW'(do_pop);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/npu_job_sequencer.sv
// npu_job_sequencer: per-job NPU reset/start handshake, watchdog and result queue.
// Build option NPU_SEQ_CYCLE_COUNT_EN stores start->result latency in res_cycles.
module npu_job_sequencer
    import npu_seq_pkg::*;
#(
    parameter int RST_CYCLES  = 2,
    parameter int START_DELAY = 2,
    parameter int CLASS_W     = 4,
    parameter int RES_DEPTH   = 8,
    parameter int TMO_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [TMO_W-1:0]   tmo_limit,
    output logic               npu_rst,
    output logic               npu_start,
    input  logic               npu_input_taken,
    input  logic               npu_valid_out,
    input  logic [CLASS_W-1:0] npu_class,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CLASS_W-1:0] res_class,
    output logic               res_timeout,
    output logic [TMO_W-1:0]   res_cycles,
    output logic               busy,
    output logic [15:0]        job_count
);

    localparam int          EW       = entry_w(CLASS_W, TMO_W);
    localparam int          TO       = to_bit(CLASS_W);
    localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
    localparam logic [15:0] GAP_LAST = 16'(START_DELAY - 1);

    state_t                     state;
    logic [15:0]                phase;
    logic [TMO_W-1:0]           wd;
    logic [TMO_W-1:0]           limit;
    logic [CLASS_W-1:0]         class_q;
    logic                       timeout_q;
    logic                       wd_hit;
    logic                       run_done;
    logic                       job_end;
    logic [EW-1:0]              entry;
    logic [EW-1:0]              head;
    logic                       full;
    logic                       empty;
    logic [$clog2(RES_DEPTH):0] res_count;

    assign wd_hit      = (limit != '0) && (wd == limit);
    assign run_done    = (state == S_RUN) && npu_valid_out;
    assign job_end     = run_done || ((state == S_START || state == S_RUN) && wd_hit);
    assign cmd_ready   = (state == S_IDLE) && !full;
    assign busy        = state != S_IDLE;
    assign res_valid   = !empty;
    assign res_class   = head[CLASS_W-1:0];
    assign res_timeout = head[TO];

    // Job sequencing: reset pulse, settle gap, start handshake, then result or watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            npu_rst   <= 1'b1;
            npu_start <= 1'b0;
            phase     <= '0;
            wd        <= '0;
            limit     <= '0;
            class_q   <= '0;
            timeout_q <= 1'b0;
            job_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    npu_rst <= cmd_valid && cmd_ready;
                    if (cmd_valid && cmd_ready) begin
                        state <= S_NRST;
                        phase <= '0;
                        limit <= tmo_limit;
                    end
                end
                S_NRST: begin
                    phase <= (phase == RST_LAST) ? '0 : phase + 16'd1;
                    if (phase == RST_LAST) begin
                        npu_rst <= 1'b0;
                        if (START_DELAY == 0) begin
                            state     <= S_START;
                            npu_start <= 1'b1;
                            wd        <= '0;
                        end else begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    phase <= phase + 16'd1;
                    if (phase == GAP_LAST) begin
                        state     <= S_START;
                        npu_start <= 1'b1;
                        wd        <= '0;
                    end
                end
                S_START, S_RUN: begin
                    wd <= wd + TMO_W'(1);
                    if (run_done) begin
                        state     <= S_PUSH;
                        class_q   <= npu_class;
                        timeout_q <= 1'b0;
                    end else if (wd_hit) begin
                        state     <= S_PUSH;
                        npu_start <= 1'b0;
                        class_q   <= '0;
                        timeout_q <= 1'b1;
                    end else if (state == S_START && npu_input_taken) begin
                        state     <= S_RUN;
                        npu_start <= 1'b0;
                    end
                end
                S_PUSH: begin
                    state     <= S_IDLE;
                    job_count <= job_count + 16'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef NPU_SEQ_CYCLE_COUNT_EN
    logic [TMO_W-1:0] cycles_q;

    // Snapshot the watchdog count on the cycle the job ends.
    always_ff @(posedge clk) begin
        if (rst) cycles_q <= '0;
        else if (job_end) cycles_q <= wd;
    end

    assign entry      = {cycles_q, timeout_q, class_q};
    assign res_cycles = head[cyc_lsb(CLASS_W) +: TMO_W];
`else
    assign entry      = {timeout_q, class_q};
    assign res_cycles = '0;
`endif

    npu_result_fifo #(
        .WIDTH (EW),
        .DEPTH (RES_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (state == S_PUSH),
        .din   (entry),
        .pop   (res_ready),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (res_count)
    );

    // Only one job is ever in flight and acceptance needed a free slot, so PUSH never sees a full queue.
    assert property (@(posedge clk) disable iff (rst) (state == S_PUSH) |-> (int'(res_count) < RES_DEPTH));

endmodule

// File: tb/tb_npu_job_sequencer.sv
// tb_npu_job_sequencer: directed scenarios plus random traffic against a job-timeline model.
`timescale 1ns/1ps
module tb_npu_job_sequencer;

    localparam int RST_CYCLES  = 2;
    localparam int START_DELAY = 2;
    localparam int CLASS_W     = 4;
    localparam int RES_DEPTH   = 8;
    localparam int TMO_W       = 16;
    localparam int S           = RST_CYCLES + START_DELAY;
`ifdef NPU_SEQ_CYCLE_COUNT_EN
    localparam bit CYC = 1'b1;
`else
    localparam bit CYC = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               cmd_valid;
    logic               cmd_ready;
    logic [TMO_W-1:0]   tmo_limit;
    logic               npu_rst;
    logic               npu_start;
    logic               npu_input_taken;
    logic               npu_valid_out;
    logic [CLASS_W-1:0] npu_class;
    logic               res_valid;
    logic               res_ready;
    logic [CLASS_W-1:0] res_class;
    logic               res_timeout;
    logic [TMO_W-1:0]   res_cycles;
    logic               busy;
    logic [15:0]        job_count;

    always #5 clk = ~clk;

    npu_job_sequencer #(
        .RST_CYCLES  (RST_CYCLES),
        .START_DELAY (START_DELAY),
        .CLASS_W     (CLASS_W),
        .RES_DEPTH   (RES_DEPTH),
        .TMO_W       (TMO_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .tmo_limit       (tmo_limit),
        .npu_rst         (npu_rst),
        .npu_start       (npu_start),
        .npu_input_taken (npu_input_taken),
        .npu_valid_out   (npu_valid_out),
        .npu_class       (npu_class),
        .res_valid       (res_valid),
        .res_ready       (res_ready),
        .res_class       (res_class),
        .res_timeout     (res_timeout),
        .res_cycles      (res_cycles),
        .busy            (busy),
        .job_count       (job_count)
    );

    int tests  = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: one job as a timeline counted in cycles since acceptance, results in a queue.
    typedef struct {
        int cls;
        int tmo;
        int cyc;
    } res_t;

    res_t q[$];
    res_t m_pend;
    bit   m_active  = 1'b0;
    bit   m_pushing = 1'b0;
    bit   m_taken   = 1'b0;
    bit   m_nrst    = 1'b1;
    bit   m_rdy;
    bit   chk_en    = 1'b0;
    int   m_t       = 0;
    int   m_w       = 0;
    int   m_lim     = 0;
    int   m_jobs    = 0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_active  = 1'b0;
            m_pushing = 1'b0;
            m_nrst    = 1'b1;
            m_jobs    = 0;
        end else begin
            m_rdy  = !m_active && q.size() < RES_DEPTH;
            m_nrst = 1'b0;
            if (res_ready && q.size() > 0) void'(q.pop_front());
            if (m_pushing) begin
                q.push_back(m_pend);
                m_jobs    = (m_jobs + 1) % 65536;
                m_active  = 1'b0;
                m_pushing = 1'b0;
            end else if (m_active) begin
                m_w = m_t - S;
                if (m_t >= S) begin
                    if (m_taken && npu_valid_out) begin
                        m_pend    = '{int'(npu_class), 0, m_w};
                        m_pushing = 1'b1;
                    end else if (m_lim != 0 && m_w == m_lim) begin
                        m_pend    = '{0, 1, m_w};
                        m_pushing = 1'b1;
                    end else if (npu_input_taken) begin
                        m_taken = 1'b1;
                    end
                end
                m_t++;
            end else if (cmd_valid && m_rdy) begin
                m_active = 1'b1;
                m_t      = 0;
                m_taken  = 1'b0;
                m_lim    = int'(tmo_limit);
            end
        end
        chk_en = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("npu_rst", npu_rst, m_active ? (m_t < RST_CYCLES) : m_nrst);
            check("npu_start", npu_start, m_active && !m_pushing && m_t >= S && !m_taken);
            check("busy", busy, m_active);
            check("cmd_ready", cmd_ready, !m_active && q.size() < RES_DEPTH);
            check("res_valid", res_valid, q.size() > 0);
            check("job_count", job_count, m_jobs);
            if (q.size() > 0) begin
                check("res_class", res_class, q[0].cls);
                check("res_timeout", res_timeout, q[0].tmo);
                check("res_cycles", res_cycles, CYC ? q[0].cyc : 0);
            end
        end
    end

    task automatic run_job(input int cls, input bit pop_at_push);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (S) tick();
        npu_input_taken = 1'b1;
        tick();
        npu_input_taken = 1'b0;
        repeat (3) tick();
        npu_valid_out = 1'b1;
        npu_class     = CLASS_W'(cls);
        tick();
        npu_valid_out = 1'b0;
        res_ready     = pop_at_push;
        tick();
        res_ready = 1'b0;
    endtask

    int n;

    initial begin
        cmd_valid       = 1'b0;
        tmo_limit       = '0;
        npu_input_taken = 1'b0;
        npu_valid_out   = 1'b0;
        npu_class       = '0;
        res_ready       = 1'b0;
        rst             = 1'b1;
        repeat (3) tick();
        check("reset npu_rst", npu_rst, 1);
        check("reset npu_start", npu_start, 0);
        check("reset busy", busy, 0);
        check("reset res_valid", res_valid, 0);
        check("reset job_count", job_count, 0);
        rst = 1'b0;
        tick();
        check("npu_rst release", npu_rst, 0);

        // Nominal job: class 7, result 2 cycles after valid_out.
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("t1 npu_rst after accept", npu_rst, 1);
        n = 0;
        while (!npu_start && n < 50) begin
            tick();
            n++;
        end
        check("t1 accept to start", n + 1, 5);
        tick();
        tick();
        npu_input_taken = 1'b1;
        tick();
        npu_input_taken = 1'b0;
        check("t1 start drops after taken", npu_start, 0);
        repeat (27) tick();
        npu_valid_out = 1'b1;
        npu_class     = 4'd7;
        tick();
        npu_valid_out = 1'b0;
        check("t1 res_valid one cycle after", res_valid, 0);
        tick();
        check("t1 res_valid", res_valid, 1);
        check("t1 res_class", res_class, 7);
        check("t1 res_timeout", res_timeout, 0);
        check("t1 job_count", job_count, 1);
        check("t1 res_cycles", res_cycles, CYC ? 30 : 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t1 popped", res_valid, 0);

        // Watchdog expiry with no result.
        tmo_limit = 16'd20;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 100) begin
            tick();
            n++;
        end
        check("t2 accept to timeout result", n, 26);
        check("t2 res_timeout", res_timeout, 1);
        check("t2 res_class", res_class, 0);
        check("t2 npu_start low", npu_start, 0);
        check("t2 res_cycles", res_cycles, CYC ? 20 : 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Result in the same cycle as watchdog expiry wins.
        tmo_limit = 16'd10;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (S) tick();
        npu_input_taken = 1'b1;
        tick();
        npu_input_taken = 1'b0;
        repeat (9) tick();
        npu_valid_out = 1'b1;
        npu_class     = 4'd3;
        tick();
        npu_valid_out = 1'b0;
        tick();
        check("t3 res_valid", res_valid, 1);
        check("t3 res_class", res_class, 3);
        check("t3 res_timeout", res_timeout, 0);
        check("t3 res_cycles", res_cycles, CYC ? 10 : 0);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;

        // Fill the queue, pop one, push and pop together.
        tmo_limit = '0;
        for (int i = 0; i < RES_DEPTH; i++) run_job(i + 1, 1'b0);
        check("t4 full cmd_ready", cmd_ready, 0);
        check("t4 head class", res_class, 1);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t4 cmd_ready after pop", cmd_ready, 1);
        run_job(9, 1'b1);
        check("t4 push+pop cmd_ready", cmd_ready, 1);
        check("t4 push+pop head", res_class, 3);
        run_job(10, 1'b0);
        check("t4 refilled cmd_ready", cmd_ready, 0);
        res_ready = 1'b1;
        repeat (RES_DEPTH - 1) tick();
        res_ready = 1'b0;
        check("t4 last entry", res_class, 10);

        // Reset in RUN aborts the job and clears the queue.
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (S) tick();
        npu_input_taken = 1'b1;
        tick();
        npu_input_taken = 1'b0;
        repeat (2) tick();
        check("t5 busy before rst", busy, 1);
        rst = 1'b1;
        tick();
        check("t5 busy", busy, 0);
        check("t5 res_valid", res_valid, 0);
        check("t5 job_count", job_count, 0);
        check("t5 npu_rst", npu_rst, 1);
        rst             = 1'b0;
        npu_valid_out   = 1'b1;
        npu_input_taken = 1'b1;
        repeat (5) tick();
        npu_valid_out   = 1'b0;
        npu_input_taken = 1'b0;
        check("t5 stray no push", res_valid, 0);
        check("t5 stray job_count", job_count, 0);

        // Random traffic checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid       = $urandom_range(0, 3) == 0;
            tmo_limit       = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 40));
            npu_input_taken = $urandom_range(0, 2) == 0;
            npu_valid_out   = $urandom_range(0, 9) == 0;
            npu_class       = CLASS_W'($urandom);
            res_ready       = $urandom_range(0, 3) == 0;
            rst             = $urandom_range(0, 299) == 0;
            tick();
        end
        rst = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
